// File: rtl/sprite_line_shifter.sv
// Per-scanline sprite pixel generator: latches up to NUM_SPRITES row descriptors
// while idle, then emits a registered 2-bit code and palette bit per slot per pixel.
module sprite_line_shifter #(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned SPRITE_W    = 16,
    parameter int unsigned X_W         = 10,
    parameter int unsigned H_ACTIVE    = 640
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [2:0]               load_slot,
    input  logic [X_W-1:0]           load_x,
    input  logic [2*SPRITE_W-1:0]    load_pattern,
    input  logic                     load_palette,
    input  logic                     load_flip,
    input  logic                     line_start,
    input  logic                     pix_en,
    output logic [2*NUM_SPRITES-1:0] pixel_data_out,
    output logic [NUM_SPRITES-1:0]   palette_data_out,
    output logic                     out_valid,
    output logic                     line_done
);

    localparam int unsigned IDX_W = $clog2(SPRITE_W);

    typedef enum logic {
        ST_LOAD,
        ST_DRAW
    } state_t;

    state_t state_q, state_d;

    logic [NUM_SPRITES-1:0]   armed_q, armed_d;
    logic [X_W-1:0]           slot_x_q   [NUM_SPRITES];
    logic [X_W-1:0]           slot_x_d   [NUM_SPRITES];
    logic [2*SPRITE_W-1:0]    slot_pat_q [NUM_SPRITES];
    logic [2*SPRITE_W-1:0]    slot_pat_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]   slot_pal_q, slot_pal_d;
    logic [NUM_SPRITES-1:0]   slot_flip_q, slot_flip_d;
    logic [X_W-1:0]           xcnt_q, xcnt_d;
    logic [2*NUM_SPRITES-1:0] pix_q, pix_d;
    logic [NUM_SPRITES-1:0]   pal_q, pal_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;

    logic [2*NUM_SPRITES-1:0] lane_pix;
    logic [NUM_SPRITES-1:0]   lane_pal;
    logic [X_W:0]             x_end;
    logic [IDX_W-1:0]         idx;
    logic                     hit;

    // Right edge is computed one bit wider so sprites near x=max clip instead of wrapping.
    always_comb begin
        lane_pix = '0;
        lane_pal = '0;
        x_end    = '0;
        idx      = '0;
        hit      = 1'b0;
        for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
            x_end = {1'b0, slot_x_q[s]} + (X_W+1)'(SPRITE_W);
            hit   = armed_q[s] && (xcnt_q >= slot_x_q[s]) && ({1'b0, xcnt_q} < x_end);
            idx   = IDX_W'(xcnt_q - slot_x_q[s]);
            if (slot_flip_q[s]) begin
                idx = IDX_W'(SPRITE_W - 1) - idx;
            end
            if (hit) begin
                lane_pix[2*s +: 2] = slot_pat_q[s][{idx, 1'b0} +: 2];
                lane_pal[s]        = slot_pal_q[s];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        slot_x_d    = slot_x_q;
        slot_pat_d  = slot_pat_q;
        slot_pal_d  = slot_pal_q;
        slot_flip_d = slot_flip_q;
        xcnt_d      = xcnt_q;
        pix_d       = '0;
        pal_d       = '0;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        load_ready  = (state_q == ST_LOAD);

        if (load_valid && load_ready) begin
            slot_x_d[load_slot]    = load_x;
            slot_pat_d[load_slot]  = load_pattern;
            slot_pal_d[load_slot]  = load_palette;
            slot_flip_d[load_slot] = load_flip;
            armed_d[load_slot]     = 1'b1;
        end

        case (state_q)
            ST_LOAD: begin
                if (line_start) begin
                    state_d = ST_DRAW;
                    xcnt_d  = '0;
                end
            end
            ST_DRAW: begin
                if (pix_en) begin
                    pix_d   = lane_pix;
                    pal_d   = lane_pal;
                    valid_d = 1'b1;
                    if (xcnt_q == X_W'(H_ACTIVE - 1)) begin
                        state_d = ST_LOAD;
                        armed_d = '0;
                        xcnt_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        xcnt_d = xcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q     <= '0;
            slot_pal_q  <= '0;
            slot_flip_q <= '0;
            xcnt_q      <= '0;
            pix_q       <= '0;
            pal_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
                slot_x_q[s]   <= '0;
                slot_pat_q[s] <= '0;
            end
        end else begin
            armed_q     <= armed_d;
            slot_pal_q  <= slot_pal_d;
            slot_flip_q <= slot_flip_d;
            xcnt_q      <= xcnt_d;
            pix_q       <= pix_d;
            pal_q       <= pal_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
                slot_x_q[s]   <= slot_x_d[s];
                slot_pat_q[s] <= slot_pat_d[s];
            end
        end
    end

    assign pixel_data_out   = pix_q;
    assign palette_data_out = pal_q;
    assign out_valid        = valid_q;
    assign line_done        = done_q;

endmodule

// File: tb/tb_sprite_line_shifter.sv
// Bench for sprite_line_shifter: directed scenarios plus random lines, each pixel
// compared against a descriptor-table reference model.
module tb_sprite_line_shifter;

    localparam int NS = 8;
    localparam int SW = 16;
    localparam int XW = 10;
    localparam int HA = 640;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            load_valid;
    logic            load_ready;
    logic [2:0]      load_slot;
    logic [XW-1:0]   load_x;
    logic [2*SW-1:0] load_pattern;
    logic            load_palette;
    logic            load_flip;
    logic            line_start;
    logic            pix_en;
    logic [2*NS-1:0] pixel_data_out;
    logic [NS-1:0]   palette_data_out;
    logic            out_valid;
    logic            line_done;

    always #5 clk = ~clk;

    sprite_line_shifter #(
        .NUM_SPRITES(NS),
        .SPRITE_W   (SW),
        .X_W        (XW),
        .H_ACTIVE   (HA)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_slot       (load_slot),
        .load_x          (load_x),
        .load_pattern    (load_pattern),
        .load_palette    (load_palette),
        .load_flip       (load_flip),
        .line_start      (line_start),
        .pix_en          (pix_en),
        .pixel_data_out  (pixel_data_out),
        .palette_data_out(palette_data_out),
        .out_valid       (out_valid),
        .line_done       (line_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the descriptor table as plain integers.
    int          m_x     [NS];
    logic [31:0] m_pat   [NS];
    bit          m_pal   [NS];
    bit          m_flip  [NS];
    bit          m_armed [NS];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < NS; s++) m_armed[s] = 1'b0;
    endfunction

    function automatic void model_set(input int slot, input int x, input logic [31:0] pat,
                                      input bit pal, input bit flip);
        m_x[slot]     = x;
        m_pat[slot]   = pat;
        m_pal[slot]   = pal;
        m_flip[slot]  = flip;
        m_armed[slot] = 1'b1;
    endfunction

    function automatic void model_expect(input int x, output logic [15:0] ep, output logic [7:0] el);
        int k;
        ep = '0;
        el = '0;
        for (int s = 0; s < NS; s++) begin
            if (m_armed[s] && x >= m_x[s] && x < m_x[s] + SW) begin
                k = x - m_x[s];
                if (m_flip[s]) k = SW - 1 - k;
                ep[2*s +: 2] = 2'((m_pat[s] >> (2 * k)) & 32'd3);
                el[s]        = m_pal[s];
            end
        end
    endfunction

    task automatic drive_desc(input int slot, input int x, input logic [31:0] pat,
                              input bit pal, input bit flip);
        load_slot    = 3'(slot);
        load_x       = XW'(x);
        load_pattern = pat;
        load_palette = pal;
        load_flip    = flip;
    endtask

    task automatic do_load(input int slot, input int x, input logic [31:0] pat,
                           input bit pal, input bit flip);
        drive_desc(slot, x, pat, pal, flip);
        load_valid = 1'b1;
        chk("load_ready_idle", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        model_set(slot, x, pat, pal, flip);
    endtask

    task automatic start_line(input bit ld, input int slot, input int x, input logic [31:0] pat,
                              input bit pal, input bit flip);
        pix_en     = 1'b0;
        line_start = 1'b1;
        if (ld) begin
            drive_desc(slot, x, pat, pal, flip);
            load_valid = 1'b1;
            chk("load_ready_at_start", 32'(load_ready), 32'd1);
        end
        step();
        line_start = 1'b0;
        load_valid = 1'b0;
        if (ld) model_set(slot, x, pat, pal, flip);
        chk("start_valid", 32'(out_valid), 32'd0);
        chk("start_pix", 32'(pixel_data_out), 32'd0);
    endtask

    task automatic run_line(input int npix, input int stall_pct, input int stall_at,
                            input bit hold_load, input bit noise_ls);
        logic [15:0] ep;
        logic [7:0]  el;
        for (int p = 0; p < npix; p++) begin
            pix_en     = 1'b1;
            line_start = noise_ls && ($urandom_range(0, 7) == 0);
            if (hold_load) chk("load_ready_draw", 32'(load_ready), 32'd0);
            step();
            model_expect(p, ep, el);
            chk($sformatf("valid@%0d", p), 32'(out_valid), 32'd1);
            chk($sformatf("pix@%0d", p), 32'(pixel_data_out), 32'(ep));
            chk($sformatf("pal@%0d", p), 32'(palette_data_out), 32'(el));
            chk($sformatf("done@%0d", p), 32'(line_done), (p == HA - 1) ? 32'd1 : 32'd0);
            if (p < HA - 1 && (p == stall_at || $urandom_range(0, 99) < 32'(stall_pct))) begin
                pix_en     = 1'b0;
                line_start = noise_ls && ($urandom_range(0, 3) == 0);
                step();
                chk($sformatf("stall_valid@%0d", p), 32'(out_valid), 32'd0);
                chk($sformatf("stall_pix@%0d", p), 32'(pixel_data_out), 32'd0);
                chk($sformatf("stall_pal@%0d", p), 32'(palette_data_out), 32'd0);
                chk($sformatf("stall_done@%0d", p), 32'(line_done), 32'd0);
            end
        end
        pix_en     = 1'b0;
        line_start = 1'b0;
        if (npix == HA) model_clear();
    endtask

    initial begin
        logic [31:0] rpat;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        line_start = 1'b0;
        pix_en     = 1'b0;
        drive_desc(0, 0, '0, 1'b0, 1'b0);
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pix", 32'(pixel_data_out), 32'd0);
        chk("rst_pal", 32'(palette_data_out), 32'd0);
        chk("rst_done", 32'(line_done), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_ready", 32'(load_ready), 32'd1);

        // Solid sprite at x=10
        do_load(0, 10, 32'hFFFF_FFFF, 1'b1, 1'b0);
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        run_line(HA, 0, -1, 1'b0, 1'b0);

        // Mirror test: unflipped then flipped
        do_load(3, 0, 32'h8000_0001, 1'b0, 1'b0);
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        run_line(HA, 0, -1, 1'b0, 1'b0);
        do_load(3, 0, 32'h8000_0001, 1'b0, 1'b1);
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        run_line(HA, 0, -1, 1'b0, 1'b0);

        // Right-edge clipping, then an empty line
        do_load(7, 630, 32'hAAAA_AAAA, 1'b1, 1'b0);
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        run_line(HA, 0, -1, 1'b0, 1'b0);
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        run_line(HA, 0, -1, 1'b0, 1'b0);

        // Descriptor held through DRAW transfers on first LOAD cycle
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        drive_desc(5, 100, 32'h1B1B_E4E4, 1'b1, 1'b0);
        load_valid = 1'b1;
        run_line(HA, 0, -1, 1'b1, 1'b0);
        chk("ready_after_line", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        model_set(5, 100, 32'h1B1B_E4E4, 1'b1, 1'b0);
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        run_line(HA, 0, -1, 1'b0, 1'b0);

        // Stall after x=20
        do_load(1, 20, 32'h0000_0009, 1'b0, 1'b0);
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        run_line(HA, 0, 20, 1'b0, 1'b0);

        // Reset mid-line
        do_load(0, 290, $urandom(), 1'b1, 1'b0);
        do_load(4, 295, $urandom(), 1'b0, 1'b1);
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        run_line(300, 0, -1, 1'b0, 1'b0);
        pix_en  = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_pix", 32'(pixel_data_out), 32'd0);
        chk("midrst_pal", 32'(palette_data_out), 32'd0);
        chk("midrst_done", 32'(line_done), 32'd0);
        model_clear();
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk("postrst_ready", 32'(load_ready), 32'd1);
        step();
        chk("postrst_valid", 32'(out_valid), 32'd0);
        chk("postrst_pix", 32'(pixel_data_out), 32'd0);
        pix_en = 1'b0;
        start_line(1'b0, 0, 0, '0, 1'b0, 1'b0);
        run_line(HA, 0, -1, 1'b0, 1'b0);

        // Random lines: overwrites, clipping, stalls, spurious line_start
        for (int ln = 0; ln < 6; ln++) begin
            int nl;
            nl = int'($urandom_range(0, 12));
            for (int i = 0; i < nl; i++) begin
                rpat = $urandom();
                do_load(int'($urandom_range(0, NS - 1)),
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, HA - 1))
                                                    : int'($urandom_range(0, 1023)),
                        rpat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            rpat = $urandom();
            start_line(1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)),
                       int'($urandom_range(0, HA - 1)), rpat,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_line(HA, 20, -1, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
